// File: rtl/clk_en_gen_pkg.sv
// Shared constants and lock FSM encoding for the clock-enable manager.
// Chip top imports the same defaults so board and core agree on settle time.
package clk_en_gen_pkg;

  localparam int DEF_CH_NUM          = 2;
  localparam int DEF_DIV_W           = 8;
  localparam int DEF_LOCK_CYCLES     = 16;
  localparam int DEF_LOCK_CNT_W      = 5;
  localparam int DEF_RST_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    LOCK_IDLE   = 2'd0,
    LOCK_SETTLE = 2'd1,
    LOCK_LOCKED = 2'd2
  } lock_state_e;

endpackage : clk_en_gen_pkg

// File: rtl/clk_en_gen_if.sv
// Control/status bundle between the chip top (master) and the clock-enable
// manager (slave). Clock and board reset stay as plain ports.
interface clk_en_gen_if #(
  parameter int CH_NUM = clk_en_gen_pkg::DEF_CH_NUM,
  parameter int DIV_W  = clk_en_gen_pkg::DEF_DIV_W
);

  logic                    en;
  logic [CH_NUM*DIV_W-1:0] div;
  logic [CH_NUM-1:0]       ce_out;
  logic [CH_NUM-1:0]       phase_out;
  logic                    locked;
  logic                    sys_reset_;

  modport master (
    output en, div,
    input  ce_out, phase_out, locked, sys_reset_
  );

  modport slave (
    input  en, div,
    output ce_out, phase_out, locked, sys_reset_
  );

endinterface : clk_en_gen_if

// File: rtl/clk_en_gen_div.sv
// One divided clock-enable channel: period is latched divide + 1 cycles,
// divide reloads only at a period boundary so no short periods occur.
module clk_en_div
  import clk_en_gen_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             ce_o,
  output logic             phase_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             ce_q, ce_d;
  logic             phase_q, phase_d;
  logic             hit;

  // Next-state for counter, latched divide, pulse and phase.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    cnt_d   = cnt_q;
    div_d   = div_q;
    ce_d    = 1'b0;
    phase_d = phase_q;
    hit     = (cnt_q == div_q);
    if (!run_i) begin
      cnt_d   = '0;
      div_d   = div_i;
      phase_d = 1'b0;
    end else if (hit) begin
      // Counter compares against the latched N, so it never exceeds
      // 2**DIV_W-1 and cannot overflow.
      cnt_d   = '0;
      div_d   = div_i;
      ce_d    = 1'b1;
      phase_d = ~phase_q;
    end else begin
      cnt_d   = cnt_q + 1'b1;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values,
    // independent of statement order.
    if (!rst_n) begin
      cnt_q   <= '0;
      div_q   <= '0;
      ce_q    <= 1'b0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      ce_q    <= ce_d;
      phase_q <= phase_d;
    end
  end

  assign ce_o    = ce_q;
  assign phase_o = phase_q;

endmodule : clk_en_div

// File: rtl/clk_en_gen.sv
// Clock-enable manager: lock FSM with programmable settle, downstream reset
// synchroniser and CH_NUM divided enable channels, all on one clock.
module clk_en_gen
  import clk_en_gen_pkg::*;
#(
  parameter int CH_NUM          = DEF_CH_NUM,
  parameter int DIV_W           = DEF_DIV_W,
  parameter int LOCK_CYCLES     = DEF_LOCK_CYCLES,
  parameter int LOCK_CNT_W      = DEF_LOCK_CNT_W,
  parameter int RST_SYNC_STAGES = DEF_RST_SYNC_STAGES
) (
  input  logic         clk,
  input  logic         reset_,
  clk_en_gen_if.slave  bus
);

  lock_state_e                state_q, state_d;
  logic [LOCK_CNT_W-1:0]      cnt_q, cnt_d;
  logic                       locked_q, locked_d;
  logic [RST_SYNC_STAGES-1:0] sync_q, sync_d;
  logic                       ch_run;
  logic [CH_NUM-1:0]          ce_vec;
  logic [CH_NUM-1:0]          phase_vec;

  // Lock FSM next-state: en low from any state returns to IDLE immediately.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      LOCK_IDLE: begin
        cnt_d = '0;
        if (bus.en) state_d = LOCK_SETTLE;
      end
      LOCK_SETTLE: begin
        if (!bus.en) begin
          state_d = LOCK_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LOCK_CNT_W'(LOCK_CYCLES - 1)) begin
          state_d = LOCK_LOCKED;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      LOCK_LOCKED: begin
        cnt_d = '0;
        if (!bus.en) state_d = LOCK_IDLE;
      end
      default: begin
        state_d = LOCK_IDLE;
        cnt_d   = '0;
      end
    endcase
    locked_d = (state_d == LOCK_LOCKED);
  end

  // Deassert shifts locked through the chain; loss of lock clears it at once.
  always_comb begin
    sync_d = '0;
    if (locked_q) sync_d = (sync_q << 1) | RST_SYNC_STAGES'(1);
  end

  // Lock FSM, lock flag and reset synchroniser registers.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q  <= LOCK_IDLE;
      cnt_q    <= '0;
      locked_q <= 1'b0;
      // NOTE: the synchroniser resets to the asserted state so sys_reset_
      // drops asynchronously with reset_ and only releases through the chain.
      sync_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
      sync_q   <= sync_d;
    end
  end

  // Channels run only while locked and staying locked, so they clear on the
  // same edge that locked falls and start counting the edge after it rises.
  assign ch_run = locked_q & locked_d;

  for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
    clk_en_div #(.DIV_W(DIV_W)) u_div (
      .clk     (clk),
      .rst_n   (reset_),
      .run_i   (ch_run),
      .div_i   (bus.div[k*DIV_W +: DIV_W]),
      .ce_o    (ce_vec[k]),
      .phase_o (phase_vec[k])
    );
  end

  assign bus.ce_out     = ce_vec;
  assign bus.phase_out  = phase_vec;
  assign bus.locked     = locked_q;
  assign bus.sys_reset_ = sync_q[RST_SYNC_STAGES-1];

endmodule : clk_en_gen

// File: doc/clk_en_gen.md
Name: clk_en_gen

Overview:
- Parametrised successor to the board-level clock-manager pseudo-module.
- From one input clock, produces lock status, a synchronised downstream reset, and CH_NUM independent divided clock-enable channels, each with a 50% phase toggle.
- Sits in chip top between the board clock/reset and the CPU, bus and peripherals.
- Replaces free-running derived clocks with single-clock enables; lock assertion is delayed by a programmable settle count.

Parameters:
- CH_NUM, 2, number of divided channels (1..8).
- DIV_W, 8, width of each channel's divide value.
- LOCK_CYCLES, 16, cycles from enable to lock (>=1).
- LOCK_CNT_W, 5, lock counter width; must satisfy 2**LOCK_CNT_W > LOCK_CYCLES.
- RST_SYNC_STAGES, 2, flop stages between lock and sys_reset_ release (>=1).

Ports:
- clk  in  1  sole clock.
- reset_  in  1  asynchronous active-low reset.
- en  in  1  manager enable; low acts as run-time reset of lock and channels.
- div  in  CH_NUM*DIV_W  per-channel divide value N; channel k uses div[k*DIV_W +: DIV_W]; period is N+1 cycles.
- ce_out  out  CH_NUM  one-cycle clock-enable pulse per channel period.
- phase_out  out  CH_NUM  toggles on each ce_out pulse (derived 50% clock, registered).
- locked  out  1  high when settled.
- sys_reset_  out  1  active-low reset for downstream logic.

Behaviour:
- Reset (reset_ low, asynchronous): ce_out=0, phase_out=0, locked=0, sys_reset_=0, lock counter=0, channel counters=0, latched divides=0.
- Lock FSM states:
  - IDLE: en=0, counter held at 0.
  - SETTLE: counting.
  - LOCKED.
- Lock FSM transitions:
  - IDLE->SETTLE on en=1.
  - SETTLE increments each cycle. Reaching LOCKED_CYCLES-1 moves to LOCKED, and locked rises on the next edge. locked first reads 1 exactly LOCK_CYCLES cycles after the edge that samples en=1.
  - Any state->IDLE when en=0 is sampled. locked falls on that same edge. The counter clears.
  - en dropping during SETTLE restarts the settle from 0 on re-enable.
- sys_reset_:
  - Assertion (low) is immediate and combinational from reset_, plus registered from locked=0 on the next edge.
  - Deassertion passes locked through RST_SYNC_STAGES flops. It rises RST_SYNC_STAGES cycles after locked rises.
- Channel k while locked=0:
  - Counter held at 0; ce_out[k]=0; phase_out[k]=0.
  - The latched divide is loaded from div each cycle.
- Channel k while locked=1:
  - Counter increments.
  - When counter == latched N: ce_out[k]=1 registered on the next edge, counter wraps to 0, phase_out[k] toggles together with ce_out, and the latched divide reloads from div.
  - A div change therefore takes effect only at a period boundary. There are no glitch or short periods.
- N=0: ce_out[k] stays high every cycle while locked; phase_out[k] toggles every cycle.
- N=2**DIV_W-1: period 2**DIV_W; the counter is DIV_W bits and must not overflow.
- First pulse: the first ce_out[k] appears N+1 cycles after locked rises.
- Channels are independent and mutually phase-aligned at lock (all counters start at 0 together).
- en falling mid-period: ce_out and phase_out clear on the same edge locked falls. No partial-period pulse is emitted.
- All outputs are registered except the asynchronous assertion of sys_reset_.

Decomposition:
- Shared package/header: lock FSM state encodings (IDLE/SETTLE/LOCKED, 2 bits) and default DIV_W/LOCK_CYCLES constants. Chip top references the same values.
- Sub-module clk_en_div: one channel (counter, latched divide, ce/phase registers). Instantiated CH_NUM times in a generate loop.
- The top contains the lock FSM and the reset synchroniser.

Test Plan:
- Reset then en=1 with LOCK_CYCLES=16 -> locked rises exactly 16 cycles after en sampled; sys_reset_ rises 2 cycles later; all ce_out=0 before locked.
- div ch0=3, ch1=0 after lock:
  - ch0 -> ce_out[0] pulses every 4 cycles, first pulse 4 cycles after locked; phase_out[0] period 8.
  - ch1 -> ce_out[1] constantly 1; phase_out[1] toggles every cycle.
- ch0 div changed 3->9 at count 1 -> remaining pulse still after a 4-cycle period; subsequent periods 10 cycles.
- ch0 div=255 (DIV_W=8) -> pulse every 256 cycles, no counter overflow, phase period 512.
- en dropped at settle count 10, re-raised 3 cycles later -> locked rises 16 cycles after re-raise. en dropped while locked -> locked, ce_out, phase_out all 0 on the same edge; sys_reset_ low next edge.
- reset_ pulsed low mid-period while locked -> all outputs 0 immediately (asynchronous). Full 16-cycle settle is required after release.
